// File: rtl/atm_auth_engine.sv
// ---------------------------------------------------------------------------
// atm_auth_engine
//
// Sequential account authenticator. A request (account number + PIN) is taken
// over a valid/ready handshake. The engine then walks the account table one
// entry per cycle, checks the PIN of the matching entry and returns a
// registered response strobe. Each entry carries a consecutive-failure
// counter and a lock bit. A programming port rewrites an entry's PIN and
// clears its counter and lock.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req_valid      request present
//   req_ready      engine idle, request will be taken
//   req_acc        account number (entry i holds account i+1)
//   req_pin        entered PIN
//   rsp_valid      one-cycle response strobe
//   rsp_found      account exists in the table
//   rsp_auth       PIN correct and account not locked
//   rsp_locked     account locked after this request
//   rsp_index      matched table index (0 when not found)
//   rsp_tries_left remaining attempts after update (0 when not found)
//   prog_en        PIN write strobe, accepted in any state
//   prog_index     entry to write (out-of-range indices are ignored)
//   prog_pin       new PIN for that entry
// ---------------------------------------------------------------------------
module atm_auth_engine #(
   parameter int               NUM_ACCOUNTS = 10,
   parameter int               ACC_W        = 4,
   parameter int               PIN_W        = 16,
   parameter int               MAX_TRIES    = 3,
   parameter logic [PIN_W-1:0] DEFAULT_PIN  = '0,
   localparam int              IDX_W        = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1,
   localparam int              TRY_W        = $clog2(MAX_TRIES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [ACC_W-1:0] req_acc,
   input  logic [PIN_W-1:0] req_pin,
   output logic             rsp_valid,
   output logic             rsp_found,
   output logic             rsp_auth,
   output logic             rsp_locked,
   output logic [IDX_W-1:0] rsp_index,
   output logic [TRY_W-1:0] rsp_tries_left,
   input  logic             prog_en,
   input  logic [IDX_W-1:0] prog_index,
   input  logic [PIN_W-1:0] prog_pin
);

   localparam logic [TRY_W-1:0] MAX_T    = TRY_W'(MAX_TRIES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACCOUNTS - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      CHECK,
      RESP
   } state_t;

   state_t state;
   state_t next_state;

   logic [ACC_W-1:0] acc_q;
   logic [PIN_W-1:0] pin_q;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] match_idx;
   logic             scan_done;
   logic             acc_hit;

   logic [PIN_W-1:0] pin_tab  [NUM_ACCOUNTS];
   logic [TRY_W-1:0] fail_cnt [NUM_ACCOUNTS];
   logic             lock_tab [NUM_ACCOUNTS];

   logic             prog_ok;
   logic [TRY_W-1:0] cur_cnt;
   logic             cur_lock;
   logic             pin_ok;
   logic [TRY_W-1:0] new_cnt;
   logic             new_lock;
   logic             chk_auth;
   logic [TRY_W-1:0] chk_tries_left;

   // Entry idx holds account idx+1. Once the scan is exhausted no further
   // comparison is made.
   assign acc_hit = !scan_done && (acc_q == (ACC_W'(idx) + ACC_W'(1)));
   assign prog_ok = prog_en && (32'(prog_index) < NUM_ACCOUNTS);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. After the last entry misses, the scan spends one
   // more cycle in SEARCH with scan_done set, so a miss answers in the same
   // cycle as a hit on the last entry would.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req_valid) next_state = SEARCH;
         SEARCH: begin
            if (scan_done) begin
               next_state = RESP;
            end else if (acc_hit) begin
               next_state = CHECK;
            end
         end
         CHECK:   next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      req_ready = (state == IDLE);
   end

   // PIN / counter evaluation for the matched entry. A locked entry keeps
   // its counter; a correct PIN clears it; a wrong PIN advances it,
   // saturating at MAX_TRIES, and reaching MAX_TRIES locks the entry.
   always_comb begin
      cur_cnt  = fail_cnt[match_idx];
      cur_lock = lock_tab[match_idx];
      pin_ok   = (pin_tab[match_idx] == pin_q);
      new_cnt  = cur_cnt;
      new_lock = cur_lock;
      chk_auth = 1'b0;
      if (!cur_lock) begin
         if (pin_ok) begin
            new_cnt  = '0;
            chk_auth = 1'b1;
         end else begin
            if (cur_cnt < MAX_T) begin
               new_cnt = cur_cnt + TRY_W'(1);
            end
            new_lock = (new_cnt == MAX_T);
         end
      end
      chk_tries_left = MAX_T - new_cnt;
   end

   // Request capture and table scan.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         pin_q     <= '0;
         idx       <= '0;
         match_idx <= '0;
         scan_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  acc_q     <= req_acc;
                  pin_q     <= req_pin;
                  idx       <= '0;
                  scan_done <= 1'b0;
               end
            end
            SEARCH: begin
               if (acc_hit) begin
                  match_idx <= idx;
               end else if (!scan_done) begin
                  if (idx == LAST_IDX) begin
                     scan_done <= 1'b1;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Account table. The programming write is placed last so that, when it
   // targets the entry being checked in the same cycle, its cleared counter
   // and lock override the check's update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            pin_tab[i]  <= DEFAULT_PIN;
            fail_cnt[i] <= '0;
            lock_tab[i] <= 1'b0;
         end
      end else begin
         if (state == CHECK) begin
            fail_cnt[match_idx] <= new_cnt;
            lock_tab[match_idx] <= new_lock;
         end
         if (prog_ok) begin
            pin_tab[prog_index]  <= prog_pin;
            fail_cnt[prog_index] <= '0;
            lock_tab[prog_index] <= 1'b0;
         end
      end
   end

   // Response registers, loaded on the way into RESP and held until the
   // next response. rsp_valid is high only for the RESP cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid      <= 1'b0;
         rsp_found      <= 1'b0;
         rsp_auth       <= 1'b0;
         rsp_locked     <= 1'b0;
         rsp_index      <= '0;
         rsp_tries_left <= '0;
      end else begin
         rsp_valid <= 1'b0;
         if (state == CHECK) begin
            rsp_valid      <= 1'b1;
            rsp_found      <= 1'b1;
            rsp_auth       <= chk_auth;
            rsp_locked     <= new_lock;
            rsp_index      <= match_idx;
            rsp_tries_left <= chk_tries_left;
         end else if ((state == SEARCH) && scan_done) begin
            rsp_valid      <= 1'b1;
            rsp_found      <= 1'b0;
            rsp_auth       <= 1'b0;
            rsp_locked     <= 1'b0;
            rsp_index      <= '0;
            rsp_tries_left <= '0;
         end
      end
   end

endmodule
